// File: rtl/stage_fifo_if.sv
// Bus bundle between the stage FIFO and its producer/consumer/control logic.
// master = the surrounding datapath; slave = the FIFO.
interface stage_fifo_if #(
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH     = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 clr;
  logic                 wr_en;
  logic [BUS_WIDTH-1:0] wr_data;
  logic                 rd_en;
  logic [BUS_WIDTH-1:0] rd_data;
  logic                 rd_valid;
  logic                 full;
  logic                 almost_full;
  logic                 empty;
  logic [CW-1:0]        count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output clr, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, almost_full, empty, count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, almost_full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/stage_fifo.sv
// Buffering FIFO feeding the enabled register bank: registered read data with a
// one-cycle rd_valid pulse, registered status flags and sticky error flags.
module stage_fifo #(
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH     = 8,
  parameter int AF_LEVEL  = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  stage_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]           rst_sync;
  logic                 rst_i_n;
  logic [BUS_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 wr_acc;
  logic                 rd_acc;
  logic [CW-1:0]        count_nxt;

  // Assert asynchronously, release two edges after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i_n = rst_sync[1];

  always_comb begin
    wr_acc    = bus.wr_en && !bus.full  && !bus.clr;
    rd_acc    = bus.rd_en && !bus.empty && !bus.clr;
    count_nxt = bus.count;
    if (bus.clr) count_nxt = '0;
    else         count_nxt = bus.count + CW'(wr_acc) - CW'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      bus.count       <= '0;
      bus.rd_data     <= '0;
      bus.rd_valid    <= 1'b0;
      bus.full        <= 1'b0;
      bus.almost_full <= 1'b0;
      bus.empty       <= 1'b1;
      bus.overflow    <= 1'b0;
      bus.underflow   <= 1'b0;
    end else begin
      bus.count       <= count_nxt;
      bus.full        <= (count_nxt == CW'(DEPTH));
      bus.almost_full <= (count_nxt >= CW'(AF_LEVEL));
      bus.empty       <= (count_nxt == '0);
      bus.rd_valid    <= rd_acc;
      if (bus.clr) begin
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        bus.overflow  <= 1'b0;
        bus.underflow <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) begin
          rd_ptr      <= rd_ptr + 1'b1;
          bus.rd_data <= mem[rd_ptr];
        end
        if (bus.wr_en && bus.full)  bus.overflow  <= 1'b1;
        if (bus.rd_en && bus.empty) bus.underflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stage_fifo.sv
// Directed bench for stage_fifo at DEPTH=4, AF_LEVEL=3, BUS_WIDTH=8.
module tb_stage_fifo;
  localparam int BW = 8;
  localparam int DP = 4;
  localparam int AF = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  stage_fifo_if #(.BUS_WIDTH(BW), .DEPTH(DP)) bus ();

  stage_fifo #(.BUS_WIDTH(BW), .DEPTH(DP), .AF_LEVEL(AF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkc(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic status(input string tag, input logic [2:0] c, input logic e,
                        input logic f, input logic a);
    chkc({tag, ".count"}, bus.count, c);
    chk1({tag, ".empty"}, bus.empty, e);
    chk1({tag, ".full"}, bus.full, f);
    chk1({tag, ".almost_full"}, bus.almost_full, a);
  endtask

  task automatic reset_vals(input string tag);
    status(tag, 3'd0, 1'b1, 1'b0, 1'b0);
    chk8({tag, ".rd_data"}, bus.rd_data, 8'h00);
    chk1({tag, ".rd_valid"}, bus.rd_valid, 1'b0);
    chk1({tag, ".overflow"}, bus.overflow, 1'b0);
    chk1({tag, ".underflow"}, bus.underflow, 1'b0);
  endtask

  task automatic write1(input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic read1(input string tag, input logic [7:0] d, input logic [2:0] c);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk8({tag, ".rd_data"}, bus.rd_data, d);
    chk1({tag, ".rd_valid"}, bus.rd_valid, 1'b1);
    chkc({tag, ".count"}, bus.count, c);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.clr = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = '0;
    repeat (3) tick();
    reset_vals("in_reset");
    rst_n = 1'b1;
    repeat (3) tick();
    reset_vals("t1");

    // t2: fill then drain, status tracks count
    for (int i = 1; i <= 4; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h11 * i);
      tick();
      status("t2.fill", 3'(i), 1'b0, (i == 4), (i >= 3));
    end
    bus.wr_en = 1'b0;
    read1("t2.r0", 8'h11, 3'd3);
    read1("t2.r1", 8'h22, 3'd2);
    read1("t2.r2", 8'h33, 3'd1);
    read1("t2.r3", 8'h44, 3'd0);
    tick();
    chk1("t2.valid_low", bus.rd_valid, 1'b0);
    chk8("t2.hold", bus.rd_data, 8'h44);
    status("t2.end", 3'd0, 1'b1, 1'b0, 1'b0);

    // t3: write while full is dropped even with a same-cycle read
    for (int i = 1; i <= 4; i++) write1(8'(8'h11 * i));
    status("t3.full", 3'd4, 1'b0, 1'b1, 1'b1);
    bus.wr_en = 1'b1; bus.wr_data = 8'h55; bus.rd_en = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    chk8("t3.rd_data", bus.rd_data, 8'h11);
    chk1("t3.overflow", bus.overflow, 1'b1);
    status("t3.after", 3'd3, 1'b0, 1'b0, 1'b1);
    read1("t3.r1", 8'h22, 3'd2);
    read1("t3.r2", 8'h33, 3'd1);
    read1("t3.r3", 8'h44, 3'd0);
    chk1("t3.empty", bus.empty, 1'b1);

    // t4: read while empty is rejected, no bypass
    bus.wr_en = 1'b1; bus.wr_data = 8'h66; bus.rd_en = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    chk1("t4.underflow", bus.underflow, 1'b1);
    chk1("t4.rd_valid", bus.rd_valid, 1'b0);
    chk8("t4.hold", bus.rd_data, 8'h44);
    status("t4.after", 3'd1, 1'b0, 1'b0, 1'b0);
    read1("t4.r", 8'h66, 3'd0);

    // t5: clear flags, then wrap pointers several times
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk1("t5.clr_ovf", bus.overflow, 1'b0);
    chk1("t5.clr_udf", bus.underflow, 1'b0);
    for (int i = 0; i < 10; i++) begin
      write1(8'(8'hA0 + i));
      chkc("t5.cnt1", bus.count, 3'd1);
      read1("t5.r", 8'(8'hA0 + i), 3'd0);
    end
    chk1("t5.ovf", bus.overflow, 1'b0);
    chk1("t5.udf", bus.underflow, 1'b0);

    // t6a: clr wins over same-cycle write and read
    for (int i = 0; i < 4; i++) write1(8'(8'hC0 + i));
    write1(8'hEE);
    chk1("t6.ovf_set", bus.overflow, 1'b1);
    chkc("t6.ovf_cnt", bus.count, 3'd4);
    read1("t6.r0", 8'hC0, 3'd3);
    read1("t6.r1", 8'hC1, 3'd2);
    bus.clr = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h77; bus.rd_en = 1'b1;
    tick();
    bus.clr = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    status("t6.clr", 3'd0, 1'b1, 1'b0, 1'b0);
    chk1("t6.clr_ovf", bus.overflow, 1'b0);
    chk1("t6.clr_udf", bus.underflow, 1'b0);
    chk1("t6.clr_valid", bus.rd_valid, 1'b0);
    chk8("t6.clr_hold", bus.rd_data, 8'hC1);

    // t6b: asynchronous reset cancels an in-flight read pulse
    write1(8'hD0);
    write1(8'hD1);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk1("t6.pre_valid", bus.rd_valid, 1'b1);
    chk8("t6.pre_data", bus.rd_data, 8'hD0);
    rst_n = 1'b0;
    #1;
    reset_vals("t6.async");
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    reset_vals("t6.released");
    write1(8'hE7);
    read1("t6.post", 8'hE7, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_fifo.md
Name: stage_fifo

Overview:
Synchronous buffering FIFO placed directly upstream of the enabled register bank in the datapath. It absorbs bursts from the producer and presents one word per accepted read. Its rd_valid output drives the downstream register's enable and its rd_data drives that register's d input. It also reports occupancy and error status to the control logic.

Parameters:
BUS_WIDTH, 8, data word width in bits; matches the downstream register bank.
DEPTH, 8, number of storage entries; power of two, at least 2.
AF_LEVEL, 6, count at or above which almost_full is asserted; legal range 1..DEPTH.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst_n  input  1  asynchronous active-low reset.
clr  input  1  synchronous flush; empties the FIFO and clears the error flags.
wr_en  input  1  write request.
wr_data  input  BUS_WIDTH  write data.
rd_en  input  1  read request.
rd_data  output  BUS_WIDTH  registered read data; feeds the downstream register d.
rd_valid  output  1  one-cycle pulse marking rd_data as new; feeds the downstream register en.
full  output  1  count == DEPTH.
almost_full  output  1  count >= AF_LEVEL.
empty  output  1  count == 0.
count  output  $clog2(DEPTH)+1  number of stored words.
overflow  output  1  sticky flag: a write was attempted while full.
underflow  output  1  sticky flag: a read was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous): pointers and count go to 0; rd_data 0; rd_valid 0; overflow 0; underflow 0; empty 1; full 0; almost_full 0. Storage contents are don't-care.
- Clock and reset: single clock domain. Reset asserts asynchronously and releases synchronously to clk, using the same two-flop release scheme as the rest of the design.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Write acceptance: a write is accepted when wr_en && !full && !clr. On acceptance, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Read acceptance: a read is accepted when rd_en && !empty && !clr. On acceptance, rd_data <= mem[rd_ptr] and rd_ptr increments.
- Read latency: rd_data and rd_valid update on the clock edge at which the read is accepted, so they are visible the cycle after rd_en is sampled. rd_valid is high for exactly one cycle per accepted read.
- rd_data hold: when no read is accepted, rd_data holds its last value and rd_valid is 0.
- Full/empty checks: full and empty are judged on registered state at the start of the cycle.
  - Write while full is rejected even if a read is accepted in the same cycle.
  - Read while empty is rejected even if a write is accepted in the same cycle. No write-to-read bypass.
- Simultaneous accepted read and write (neither full nor empty): count is unchanged and both pointers advance.
- Count update: count += accepted write, -= accepted read.
- Status outputs: full, empty and almost_full are registered. They are derived from the next count and are therefore always consistent with count.
- Overflow: set when wr_en && full && !clr. Sticky until clr or reset.
- Underflow: set when rd_en && empty && !clr. Sticky until clr or reset.
- Rejected operations: do not change pointers, count, memory or rd_data.
- clr priority: clr has priority over wr_en and rd_en. In the clr cycle, no operation is accepted and no flag is set. On the next edge:
  - pointers and count go to 0, empty = 1, full = 0, almost_full = 0;
  - overflow and underflow go to 0, rd_valid = 0;
  - rd_data holds its value.
- Reset mid-operation: an in-flight read pulse is cancelled, so rd_valid drops immediately with rst_n.

Test Plan:
DEPTH=4, AF_LEVEL=3, BUS_WIDTH=8.
1. Release reset with idle inputs -> empty=1, count=0, rd_data=0x00, rd_valid=0, full=0, almost_full=0, overflow=0, underflow=0.
2. Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then read 4 times -> count goes 1,2,3,4; almost_full rises at count 3; full at count 4. rd_data is 0x11, 0x22, 0x33, 0x44, each with a one-cycle rd_valid the cycle after its rd_en. empty=1 at the end.
3. When full, assert wr_en with 0x55 and rd_en together -> read returns 0x11, write is dropped, overflow=1, count=3. Later reads return 0x22, 0x33, 0x44, never 0x55.
4. When empty, assert rd_en with wr_en(0x66) together -> underflow=1, rd_valid=0, count=1. The next read returns 0x66.
5. Pointer wrap: run 10 write/read pairs, each write followed by a read, data 0xA0..0xA9 -> reads return 0xA0..0xA9 in order, count never exceeds 1, no flags set.
6. Partially fill (count=2) with overflow set, then assert clr with wr_en and rd_en high -> next cycle count=0, empty=1, overflow=0, rd_valid=0, rd_data unchanged. Repeat with rst_n pulsed low mid-read -> rd_valid drops immediately and all reset values are restored.
